// File: rtl/mcp_stack_unit.sv
// Operand stack for the multicycle stack processor: register-file LIFO with registered d_out.
// Optional MCP_STACK_CIRCULAR_EN: a push on a full stack overwrites the oldest entry instead of being dropped.
module mcp_stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] d_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] d_out,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    SP_ONE   = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     sp;
    logic [AW-1:0]     top_idx;

    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     sp_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              ovf_evt;
    logic              unf_evt;

    assign top_idx = sp - SP_ONE;
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);

    // A push takes precedence over tos; tos only forwards d_in when the push succeeds.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = sp;
        sp_nxt   = sp;
        cnt_nxt  = count;
        dout_nxt = d_out;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (push && pop) begin
            if (!empty) begin
                wr_en    = 1'b1;
                wr_idx   = top_idx;
                dout_nxt = mem[top_idx];
            end else begin
                wr_en   = 1'b1;
                sp_nxt  = sp + SP_ONE;
                cnt_nxt = count + CNT_ONE;
                unf_evt = 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                dout_nxt = mem[top_idx];
                sp_nxt   = top_idx;
                cnt_nxt  = count - CNT_ONE;
            end else begin
                unf_evt = 1'b1;
            end
        end else if (push) begin
            if (!full) begin
                wr_en   = 1'b1;
                sp_nxt  = sp + SP_ONE;
                cnt_nxt = count + CNT_ONE;
                if (tos) begin
                    dout_nxt = d_in;
                end
            end else begin
                ovf_evt = 1'b1;
`ifdef MCP_STACK_CIRCULAR_EN
                // When full, sp already points at the oldest entry.
                wr_en  = 1'b1;
                sp_nxt = sp + SP_ONE;
`endif
            end
        end else if (tos) begin
            if (!empty) begin
                dout_nxt = mem[top_idx];
            end else begin
                unf_evt = 1'b1;
            end
        end
    end

    // Storage is not reset, but a write is suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_idx] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp      <= '0;
            count   <= '0;
            d_out   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            sp      <= sp_nxt;
            count   <= cnt_nxt;
            d_out   <= dout_nxt;
            err_ovf <= (err_ovf && !clr_err) || ovf_evt;
            err_unf <= (err_unf && !clr_err) || unf_evt;
        end
    end

endmodule

// File: tb/tb_mcp_stack_unit.sv
// Self-checking bench for mcp_stack_unit: directed scenarios plus randomized traffic against a queue model.
// Honours MCP_STACK_CIRCULAR_EN the same way as the design.
module tb_mcp_stack_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              tos = 1'b0;
    logic [DATA_W-1:0] d_in = '0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] d_out;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              err_ovf;
    logic              err_unf;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_dout;
    logic              m_ovf;
    logic              m_unf;

    mcp_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .d_in(d_in),
        .clr_err(clr_err), .d_out(d_out), .count(count), .empty(empty), .full(full),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Behavioural reference: stack as a queue, top at the back.
    task automatic model_step(input logic pu, input logic po, input logic t,
                              input logic [DATA_W-1:0] d, input logic c);
        int  n;
        logic o, u;
        n = m_q.size();
        o = 1'b0;
        u = 1'b0;
        if (pu && po) begin
            if (n > 0) begin
                m_dout = m_q[n-1];
                m_q[n-1] = d;
            end else begin
                m_q.push_back(d);
                u = 1'b1;
            end
        end else if (po) begin
            if (n > 0) m_dout = m_q.pop_back();
            else u = 1'b1;
        end else if (pu) begin
            if (n < DEPTH) begin
                m_q.push_back(d);
                if (t) m_dout = d;
            end else begin
                o = 1'b1;
`ifdef MCP_STACK_CIRCULAR_EN
                void'(m_q.pop_front());
                m_q.push_back(d);
`endif
            end
        end else if (t) begin
            if (n > 0) m_dout = m_q[n-1];
            else u = 1'b1;
        end
        m_ovf = (m_ovf && !c) || o;
        m_unf = (m_unf && !c) || u;
    endtask

    // Apply one cycle of stimulus; returns 1ns after the edge with inputs idle.
    task automatic drive(input logic pu, input logic po, input logic t,
                         input logic [DATA_W-1:0] d, input logic c);
        push = pu; pop = po; tos = t; d_in = d; clr_err = c;
        @(posedge clk);
        model_step(pu, po, t, d, c);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (count !== '0 || d_out !== '0 || empty !== 1'b1 || full !== 1'b0 ||
            err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: count=%0d d_out=%h empty=%b full=%b ovf=%b unf=%b, required 0 00 1 0 0 0",
                     count, d_out, empty, full, err_ovf, err_unf);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_lifo();
        logic [DATA_W-1:0] exp_v [3];
        exp_v[0] = 8'h33; exp_v[1] = 8'h22; exp_v[2] = 8'h11;
        do_reset();
        drive(1, 0, 0, 8'h11, 0);
        drive(1, 0, 0, 8'h22, 0);
        drive(1, 0, 0, 8'h33, 0);
        vectors++;
        if (count !== 3) begin
            miscompares++;
            $display("FAIL lifo_count_fill: count=%0d, required 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 8'h00, 0);
            vectors++;
            if (d_out !== exp_v[i] || count !== CNT_W'(2 - i)) begin
                miscompares++;
                $display("FAIL lifo_pop%0d: d_out=%h count=%0d, required %h %0d",
                         i, d_out, count, exp_v[i], 2 - i);
            end
        end
        vectors++;
        if (empty !== 1'b1 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL lifo_end: empty=%b ovf=%b unf=%b, required 1 0 0", empty, err_ovf, err_unf);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(1, 0, 0, 8'h3C, 0);
        drive(0, 1, 0, 8'h00, 0);
        drive(0, 1, 0, 8'h00, 0);
        vectors++;
        if (err_unf !== 1'b1 || d_out !== 8'h3C || count !== '0) begin
            miscompares++;
            $display("FAIL unf_pop_empty: unf=%b d_out=%h count=%0d, required 1 3c 0", err_unf, d_out, count);
        end
        drive(0, 0, 0, 8'h00, 1);
        vectors++;
        if (err_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL unf_clear: unf=%b, required 0", err_unf);
        end
        drive(0, 0, 1, 8'h00, 0);
        vectors++;
        if (err_unf !== 1'b1 || d_out !== 8'h3C) begin
            miscompares++;
            $display("FAIL unf_tos_empty: unf=%b d_out=%h, required 1 3c", err_unf, d_out);
        end
        drive(0, 1, 0, 8'h00, 1);
        vectors++;
        if (err_unf !== 1'b1) begin
            miscompares++;
            $display("FAIL unf_clear_collide: unf=%b, required 1", err_unf);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        drive(1, 0, 0, 8'hA5, 0);
        drive(1, 1, 0, 8'h5A, 0);
        vectors++;
        if (d_out !== 8'hA5 || count !== 1) begin
            miscompares++;
            $display("FAIL pushpop: d_out=%h count=%0d, required a5 1", d_out, count);
        end
        drive(0, 0, 1, 8'h00, 0);
        vectors++;
        if (d_out !== 8'h5A || count !== 1) begin
            miscompares++;
            $display("FAIL pushpop_tos: d_out=%h count=%0d, required 5a 1", d_out, count);
        end
        do_reset();
        drive(1, 1, 0, 8'h44, 0);
        vectors++;
        if (count !== 1 || err_unf !== 1'b1 || d_out !== 8'h00) begin
            miscompares++;
            $display("FAIL pushpop_empty: count=%0d unf=%b d_out=%h, required 1 1 00", count, err_unf, d_out);
        end
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] exp;
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, DATA_W'(i), 0);
        vectors++;
        if (full !== 1'b1 || count !== CNT_W'(DEPTH) || err_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL full_fill: full=%b count=%0d ovf=%b, required 1 %0d 0", full, count, err_ovf, DEPTH);
        end
        drive(1, 0, 0, 8'hFF, 0);
        vectors++;
        if (full !== 1'b1 || count !== CNT_W'(DEPTH) || err_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL full_ovf: full=%b count=%0d ovf=%b, required 1 %0d 1", full, count, err_ovf, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, 8'h00, 0);
`ifdef MCP_STACK_CIRCULAR_EN
            exp = (i == 0) ? 8'hFF : DATA_W'(DEPTH - i);
`else
            exp = DATA_W'(DEPTH - 1 - i);
`endif
            vectors++;
            if (d_out !== exp) begin
                miscompares++;
                $display("FAIL full_drain%0d: d_out=%h, required %h", i, d_out, exp);
            end
        end
        vectors++;
        if (empty !== 1'b1 || err_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL full_drained: empty=%b ovf=%b, required 1 1", empty, err_ovf);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 1, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h10, 0);
        drive(1, 0, 0, 8'h20, 0);
        drive(1, 0, 0, 8'h30, 0);
        drive(0, 0, 1, 8'h00, 0);
        vectors++;
        if (d_out !== 8'h30 || count !== 3 || err_unf !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre: d_out=%h count=%0d unf=%b, required 30 3 1", d_out, count, err_unf);
        end
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (count !== '0 || d_out !== '0 || empty !== 1'b1 || err_unf !== 1'b0 || err_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_mid: count=%0d d_out=%h empty=%b ovf=%b unf=%b, required 0 00 1 0 0",
                     count, d_out, empty, err_ovf, err_unf);
        end
        #2;
        rst = 1'b1;
        drive(0, 1, 0, 8'h00, 0);
        vectors++;
        if (err_unf !== 1'b1 || count !== '0) begin
            miscompares++;
            $display("FAIL arst_post_pop: unf=%b count=%0d, required 1 0", err_unf, count);
        end
    endtask

    task automatic test_tos_push();
        do_reset();
        drive(1, 0, 0, 8'h01, 0);
        drive(1, 0, 0, 8'h02, 0);
        drive(1, 0, 1, 8'h7E, 0);
        vectors++;
        if (d_out !== 8'h7E || count !== 3) begin
            miscompares++;
            $display("FAIL tospush: d_out=%h count=%0d, required 7e 3", d_out, count);
        end
        drive(0, 1, 0, 8'h00, 0);
        vectors++;
        if (d_out !== 8'h7E || count !== 2) begin
            miscompares++;
            $display("FAIL tospush_pop: d_out=%h count=%0d, required 7e 2", d_out, count);
        end
    endtask

    task automatic test_random();
        logic pu, po, t, c;
        int   push_pct;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            // Alternate fill-biased and drain-biased phases so both boundaries are exercised.
            push_pct = ((cyc / 75) % 2 == 0) ? 75 : 25;
            pu = ($urandom_range(99) < push_pct);
            po = ($urandom_range(99) < (100 - push_pct));
            t  = ($urandom_range(99) < 25);
            c  = ($urandom_range(99) < 8);
            drive(pu, po, t, DATA_W'($urandom), c);
            vectors++;
            if (d_out !== m_dout || count !== CNT_W'(m_q.size()) ||
                empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH) ||
                err_ovf !== m_ovf || err_unf !== m_unf) begin
                miscompares++;
                $display("FAIL random cyc%0d: d_out=%h count=%0d e=%b f=%b ovf=%b unf=%b, required %h %0d %b %b %b %b",
                         cyc, d_out, count, empty, full, err_ovf, err_unf, m_dout, m_q.size(),
                         m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_underflow();
        test_push_pop();
        test_full();
        test_async_reset();
        test_tos_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
